demux_5digit: RTL and testbench

- Receive end of the 5-digit multiplexed display bus: 4-bit BCD plus a one-hot active-high anode strobe (bit0 = centesimas unidades … bit4 = minutos).
- Samples the scanned bus, filters slot-transition glitches, checks scan order, and rebuilds the five parallel BCD digits of M:SS:tt.
- Used on the remote/secondary display board and as the self-check monitor in the chronometer top level. Same 25 MHz domain as the scanner.

---
 rtl/demux_5digit_pkg.sv | 21 ++
 rtl/demux_5digit_stable.sv | 40 ++++
 rtl/demux_5digit.sv | 115 +++++++++++
 tb/tb_demux_5digit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/demux_5digit_pkg.sv
// demux_5digit_pkg: shared constants, FSM state type and anode decode for the 5-digit display bus
package demux_5digit_pkg;
  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W = 4;
  localparam logic [NUM_DIGITS-1:0] AN_CU = 5'b00001;
  localparam logic [NUM_DIGITS-1:0] AN_CD = 5'b00010;
  localparam logic [NUM_DIGITS-1:0] AN_SU = 5'b00100;
  localparam logic [NUM_DIGITS-1:0] AN_SD = 5'b01000;
  localparam logic [NUM_DIGITS-1:0] AN_MIN = 5'b10000;
  typedef enum logic {HUNT, COLLECT} state_t;
  function automatic logic [3:0] onehot_to_idx(input logic [NUM_DIGITS-1:0] an);
    case (an)
      AN_CU: return {1'b1, 3'd0};
      AN_CD: return {1'b1, 3'd1};
      AN_SU: return {1'b1, 3'd2};
      AN_SD: return {1'b1, 3'd3};
      AN_MIN: return {1'b1, 3'd4};
      default: return 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/demux_5digit_stable.sv
// bus_stable_filter: registers a bus and strobes once per value held STABLE_CYCLES cycles
//   clk, rst : clock, synchronous active-high reset
//   d_i      : raw bus input
//   q_o      : registered bus
//   cap_o    : one-cycle capture strobe, q_o is the captured value
module bus_stable_filter #(
  parameter int STABLE_CYCLES = 16,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         cap_o
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  logic [W-1:0] in_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cap_q, cap_d, chg;
  // chg flags that in_q takes a new value on this edge; the counter restarts with it
  always_comb begin
    chg = d_i != in_q;
    cap_o = !cap_q && cnt_q == CNT_LAST;
    cnt_d = chg ? '0 : (cnt_q == CNT_LAST ? cnt_q : cnt_q + 1'b1);
    cap_d = chg ? 1'b0 : (cap_q | cap_o);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
      cnt_q <= '0;
      cap_q <= 1'b0;
    end else begin
      in_q <= d_i;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
    end
  end
  assign q_o = in_q;
endmodule

// File: rtl/demux_5digit.sv
// demux_5digit: rebuilds five parallel BCD digits from the scanned display bus
//   clk, rst            : 25 MHz clock, synchronous active-high reset
//   bcd_mux_in          : BCD of scanned digit
//   anodos_in           : one-hot anode strobe (bit0 = t units .. bit4 = minutes)
//   d4_out..d0_out      : last published frame
//   frame_valid         : pulse after a complete in-order frame is published
//   link_ok             : frame seen and no watchdog timeout since
//   err_onehot, err_seq : pulses for bad anode value / out-of-order digit
import demux_5digit_pkg::*;
module demux_5digit #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_COUNT = 150_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    bcd_mux_in,
  input  logic [NUM_DIGITS-1:0] anodos_in,
  output logic [DIGIT_W-1:0]    d4_out,
  output logic [DIGIT_W-1:0]    d3_out,
  output logic [DIGIT_W-1:0]    d2_out,
  output logic [DIGIT_W-1:0]    d1_out,
  output logic [DIGIT_W-1:0]    d0_out,
  output logic                  frame_valid,
  output logic                  link_ok,
  output logic                  err_onehot,
  output logic                  err_seq
);
  localparam int WW = $clog2(TIMEOUT_COUNT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_COUNT - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
  logic [DIGIT_W+NUM_DIGITS-1:0] in_q;
  logic cap;
  logic [DIGIT_W-1:0] bcd;
  logic [3:0] oh;
  logic [2:0] idx;
  state_t state_q;
  logic [2:0] exp_q;
  logic [WW-1:0] wd_q;
  logic [DIGIT_W-1:0] shadow_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] dout_q [NUM_DIGITS];
  logic fv_q, link_q, eoh_q, eseq_q;
  bus_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES), .W(DIGIT_W + NUM_DIGITS)) u_filt (
    .clk(clk),
    .rst(rst),
    .d_i({bcd_mux_in, anodos_in}),
    .q_o(in_q),
    .cap_o(cap)
  );
  assign bcd = in_q[DIGIT_W+NUM_DIGITS-1:NUM_DIGITS];
  assign oh = onehot_to_idx(in_q[NUM_DIGITS-1:0]);
  assign idx = oh[2:0];
  // capture is checked before the watchdog so a capture on the timeout cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q <= '0;
      wd_q <= '0;
      shadow_q <= '{default: '0};
      dout_q <= '{default: '0};
      fv_q <= 1'b0;
      link_q <= 1'b0;
      eoh_q <= 1'b0;
      eseq_q <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      eoh_q <= 1'b0;
      eseq_q <= 1'b0;
      if (cap) begin
        wd_q <= '0;
        if (!oh[3]) begin
          eoh_q <= 1'b1;
          state_q <= HUNT;
          exp_q <= '0;
        end else if (state_q == HUNT) begin
          if (idx == 3'd0) begin
            shadow_q[0] <= bcd;
            exp_q <= 3'd1;
            state_q <= COLLECT;
          end
        end else if (idx == exp_q) begin
          shadow_q[idx] <= bcd;
          if (idx == LAST_IDX) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) dout_q[i] <= shadow_q[i];
            dout_q[NUM_DIGITS-1] <= bcd;
            fv_q <= 1'b1;
            link_q <= 1'b1;
            exp_q <= '0;
          end else begin
            exp_q <= idx + 3'd1;
          end
        end else begin
          eseq_q <= 1'b1;
          if (idx == 3'd0) begin
            shadow_q[0] <= bcd;
            exp_q <= 3'd1;
          end else begin
            state_q <= HUNT;
            exp_q <= '0;
          end
        end
      end else if (wd_q == WD_MAX) begin
        link_q <= 1'b0;
        state_q <= HUNT;
        exp_q <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end
  assign {d4_out, d3_out, d2_out, d1_out, d0_out} = {dout_q[4], dout_q[3], dout_q[2], dout_q[1], dout_q[0]};
  assign frame_valid = fv_q;
  assign link_ok = link_q;
  assign err_onehot = eoh_q;
  assign err_seq = eseq_q;
endmodule

// File: tb/tb_demux_5digit.sv
// tb_demux_5digit: directed self-checking bench for demux_5digit with a behavioural scanner
module tb_demux_5digit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] bcd_mux_in = '0;
  logic [4:0] anodos_in = '0;
  logic [3:0] d4_out, d3_out, d2_out, d1_out, d0_out;
  logic frame_valid, link_ok, err_onehot, err_seq;
  int checks = 0;
  int failures = 0;
  int fv_n = 0, eoh_n = 0, eseq_n = 0;
  int fv0, eoh0, eseq0;
  demux_5digit #(.STABLE_CYCLES(4), .TIMEOUT_COUNT(64)) dut (
    .clk(clk),
    .rst(rst),
    .bcd_mux_in(bcd_mux_in),
    .anodos_in(anodos_in),
    .d4_out(d4_out),
    .d3_out(d3_out),
    .d2_out(d2_out),
    .d1_out(d1_out),
    .d0_out(d0_out),
    .frame_valid(frame_valid),
    .link_ok(link_ok),
    .err_onehot(err_onehot),
    .err_seq(err_seq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (err_onehot) eoh_n++;
    if (err_seq) eseq_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] an, input logic [3:0] v, input int n);
    anodos_in = an;
    bcd_mux_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic slot(input int i, input logic [19:0] ds);
    drive(5'(1 << i), ds[i*4+:4], 8);
  endtask
  task automatic rot(input logic [19:0] ds);
    for (int i = 0; i < 5; i++) slot(i, ds);
  endtask
  task automatic snap();
    fv0 = fv_n;
    eoh0 = eoh_n;
    eseq0 = eseq_n;
  endtask
  function automatic logic [19:0] dout();
    return {d4_out, d3_out, d2_out, d1_out, d0_out};
  endfunction
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_digits", 32'(dout()), 32'h0);
    check("rst_flags", {28'h0, frame_valid, link_ok, err_onehot, err_seq}, 32'h0);
    rst = 1'b0;
    snap();
    rot(20'h34791);
    check("first_frame", fv_n - fv0, 1);
    rot(20'h34791);
    rot(20'h34791);
    check("frames3", fv_n - fv0, 3);
    check("digits1", 32'(dout()), 32'h34791);
    check("link1", 32'(link_ok), 1);
    check("noerr_oh1", eoh_n - eoh0, 0);
    check("noerr_seq1", eseq_n - eseq0, 0);
    snap();
    slot(0, 20'h34791);
    slot(1, 20'h34791);
    drive(5'b01100, 4'h7, 2);
    slot(2, 20'h34791);
    slot(3, 20'h34791);
    slot(4, 20'h34791);
    check("glitch_frame", fv_n - fv0, 1);
    check("glitch_no_oh", eoh_n - eoh0, 0);
    check("glitch_no_seq", eseq_n - eseq0, 0);
    snap();
    slot(0, 20'h34791);
    slot(1, 20'h34791);
    slot(2, 20'h34791);
    drive(5'b01100, 4'h7, 6);
    check("hold_oh", eoh_n - eoh0, 1);
    slot(3, 20'h34791);
    slot(4, 20'h34791);
    check("hunt_no_frame", fv_n - fv0, 0);
    rot(20'h34791);
    check("resume_frame", fv_n - fv0, 1);
    check("resume_seq0", eseq_n - eseq0, 0);
    snap();
    slot(0, 20'h88888);
    slot(1, 20'h88888);
    slot(3, 20'h88888);
    check("seq_err", eseq_n - eseq0, 1);
    check("seq_no_frame", fv_n - fv0, 0);
    rot(20'h55555);
    check("fives_frame", fv_n - fv0, 1);
    check("fives_digits", 32'(dout()), 32'h55555);
    snap();
    slot(0, 20'h55555);
    slot(1, 20'h55555);
    drive(5'b00100, 4'h5, 68);
    check("freeze_link_hi", 32'(link_ok), 1);
    drive(5'b00100, 4'h5, 1);
    check("freeze_link_lo", 32'(link_ok), 0);
    check("freeze_digits", 32'(dout()), 32'h55555);
    check("freeze_noerr", (eoh_n - eoh0) + (eseq_n - eseq0), 0);
    rot(20'h34791);
    check("relink", 32'(link_ok), 1);
    check("relink_digits", 32'(dout()), 32'h34791);
    slot(0, 20'h34791);
    slot(1, 20'h34791);
    slot(2, 20'h34791);
    check("d0_mid", 32'(dout()), 32'h34791);
    slot(3, 20'h34792);
    slot(4, 20'h34792);
    check("d0_old_frame", 32'(dout()), 32'h34791);
    rot(20'h34792);
    check("d0_new_frame", 32'(dout()), 32'h34792);
    slot(0, 20'h61234);
    slot(1, 20'h61234);
    slot(2, 20'h61234);
    drive(5'b01000, 4'h6, 4);
    rst = 1'b1;
    drive(5'b01000, 4'h6, 1);
    check("rst_mid_digits", 32'(dout()), 32'h0);
    check("rst_mid_flags", {28'h0, frame_valid, link_ok, err_onehot, err_seq}, 32'h0);
    rst = 1'b0;
    snap();
    drive(5'b01000, 4'h6, 3);
    slot(4, 20'h61234);
    check("post_rst_no_frame", fv_n - fv0, 0);
    check("post_rst_digits0", 32'(dout()), 32'h0);
    rot(20'h61234);
    check("post_rst_frame", fv_n - fv0, 1);
    check("post_rst_digits", 32'(dout()), 32'h61234);
    check("post_rst_noerr", (eoh_n - eoh0) + (eseq_n - eseq0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
